// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through read port,
// registered fill level and threshold flags, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] PTR_ZERO  = '0;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]       wr_ptr, rd_ptr;
  logic [ADDR_W:0]       rd_ptr_nxt, count_nxt;
  logic                  rd_acc, wr_acc, head_new;

  // Signed compare so out-of-range thresholds simply pin the flag high or low.
  function automatic logic af_of(input logic [ADDR_W:0] c);
    return int'(c) >= AF_THRESH;
  endfunction

  function automatic logic ae_of(input logic [ADDR_W:0] c);
    return int'(c) <= AE_THRESH;
  endfunction

  always_comb begin
    rd_acc     = rd_en && !empty;
    wr_acc     = wr_en && (!full || rd_acc);
    rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    count_nxt  = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + PTR_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - PTR_ONE;
    end
    // The word being written becomes the head when nothing else remains after this cycle's pop.
    head_new = wr_acc && (count == (rd_acc ? PTR_ONE : PTR_ZERO));
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= ae_of(PTR_ZERO);
      almost_full  <= af_of(PTR_ZERO);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= ae_of(PTR_ZERO);
      almost_full  <= af_of(PTR_ZERO);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == PTR_ZERO);
      full         <= (count_nxt == DEPTH_CNT);
      almost_empty <= ae_of(count_nxt);
      almost_full  <= af_of(count_nxt);
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
      if (FWFT != 0) begin
        rd_valid <= (count_nxt != PTR_ZERO);
        if (count_nxt != PTR_ZERO) begin
          rd_data <= head_new ? wr_data : mem[rd_ptr_nxt[ADDR_W-1:0]];
        end
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) begin
          rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one stimulus stream
// and are checked every cycle against a queue model, plus directed literal checks.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic [3:0]    s_count, f_count;
  logic          s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic          f_empty, f_full, f_ae, f_af, f_ovf, f_udf;

  int vecs = 0;
  int errs = 0;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .count(s_count), .empty(s_empty),
    .full(s_full), .almost_empty(s_ae), .almost_full(s_af), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .count(f_count), .empty(f_empty),
    .full(f_full), .almost_empty(f_ae), .almost_full(f_af), .overflow(f_ovf), .underflow(f_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, expected read port values per mode.
  logic [DW-1:0] q[$];
  bit            live = 1'b0;
  bit            m_ovf, m_udf, m_v0, m_v1;
  logic [DW-1:0] m_d0, m_d1;

  always @(posedge clk) begin
    bit racc, wacc;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0;
      live  = 1'b1;
    end else if (flush) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_v0 = 0; m_v1 = 0;
    end else begin
      racc = rd_en && (q.size() > 0);
      wacc = wr_en && ((q.size() < DEPTH) || racc);
      if (rd_en && q.size() == 0) m_udf = 1;
      if (wr_en && !wacc) m_ovf = 1;
      m_v0 = racc;
      if (racc) m_d0 = q.pop_front();
      if (wacc) q.push_back(wr_data);
      m_v1 = (q.size() > 0);
      if (q.size() > 0) m_d1 = q[0];
    end
  end

  always @(negedge clk) begin
    int n;
    if (live) begin
      n = q.size();
      chk("std.count", 32'(s_count), n);
      chk("std.empty", 32'(s_empty), 32'(n == 0));
      chk("std.full", 32'(s_full), 32'(n == DEPTH));
      chk("std.almost_empty", 32'(s_ae), 32'(n <= 4));
      chk("std.almost_full", 32'(s_af), 32'(n >= 4));
      chk("std.overflow", 32'(s_ovf), 32'(m_ovf));
      chk("std.underflow", 32'(s_udf), 32'(m_udf));
      chk("std.rd_valid", 32'(s_rd_valid), 32'(m_v0));
      chk("std.rd_data", 32'(s_rd_data), 32'(m_d0));
      chk("fwft.count", 32'(f_count), n);
      chk("fwft.empty", 32'(f_empty), 32'(n == 0));
      chk("fwft.full", 32'(f_full), 32'(n == DEPTH));
      chk("fwft.almost_empty", 32'(f_ae), 32'(n <= 4));
      chk("fwft.almost_full", 32'(f_af), 32'(n >= 4));
      chk("fwft.overflow", 32'(f_ovf), 32'(m_ovf));
      chk("fwft.underflow", 32'(f_udf), 32'(m_udf));
      chk("fwft.rd_valid", 32'(f_rd_valid), 32'(m_v1));
      chk("fwft.rd_data", 32'(f_rd_data), 32'(m_d1));
    end
  end

  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit rs);
    wr_en = w; wr_data = d; rd_en = r; flush = f; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_rd [8];
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    drive(0, 8'h00, 0, 0, 1);
    chk("lit.reset.count", 32'(s_count), 0);
    chk("lit.reset.empty", 32'(s_empty), 1);
    chk("lit.reset.almost_empty", 32'(s_ae), 1);
    chk("lit.reset.full", 32'(s_full), 0);
    chk("lit.reset.rd_data", 32'(s_rd_data), 0);

    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      chk("lit.fill.count", 32'(s_count), i);
      chk("lit.fill.almost_full", 32'(s_af), 32'(i >= 4));
      chk("lit.fill.fwft_head", 32'(f_rd_data), 32'h01);
    end
    chk("lit.fill.full", 32'(s_full), 1);

    drive(1, 8'h0A, 1, 0, 0);
    chk("lit.rw_full.rd_data", 32'(s_rd_data), 32'h01);
    chk("lit.rw_full.rd_valid", 32'(s_rd_valid), 1);
    chk("lit.rw_full.count", 32'(s_count), 8);
    chk("lit.rw_full.full", 32'(s_full), 1);
    chk("lit.rw_full.overflow", 32'(s_ovf), 0);
    chk("lit.rw_full.fwft_head", 32'(f_rd_data), 32'h02);

    drive(1, 8'h0B, 0, 0, 0);
    chk("lit.ovf.overflow", 32'(s_ovf), 1);
    chk("lit.ovf.count", 32'(s_count), 8);

    exp_rd = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      chk("lit.drain.rd_data", 32'(s_rd_data), 32'(exp_rd[i]));
      chk("lit.drain.rd_valid", 32'(s_rd_valid), 1);
    end
    chk("lit.drain.empty", 32'(s_empty), 1);

    drive(0, 8'h00, 1, 0, 0);
    chk("lit.udf.underflow", 32'(s_udf), 1);
    chk("lit.udf.count", 32'(s_count), 0);
    chk("lit.udf.rd_data", 32'(s_rd_data), 32'h0A);
    chk("lit.udf.fwft_rd_data", 32'(f_rd_data), 32'h0A);
    drive(0, 8'h00, 0, 1, 0);
    chk("lit.flush.underflow", 32'(s_udf), 0);
    chk("lit.flush.overflow", 32'(s_ovf), 0);

    // Pointers run past 2*DEPTH here.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) drive(1, 8'(8'h10 + 8'(r * 5 + i)), 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0, 0);
    end
    for (int i = 0; i < 8; i++) drive(1, 8'(8'h20 + 8'(i)), 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      chk("lit.wrap.rd_data", 32'(s_rd_data), 32'(8'h20 + 8'(i)));
    end
    chk("lit.wrap.empty", 32'(s_empty), 1);

    for (int i = 1; i <= 3; i++) drive(1, 8'(8'h30 + 8'(i)), 0, 0, 0);
    drive(1, 8'h34, 1, 0, 0);
    chk("lit.rw3.count", 32'(s_count), 3);
    chk("lit.rw3.rd_data", 32'(s_rd_data), 32'h31);
    drive(0, 8'h00, 0, 1, 0);

    drive(1, 8'hA5, 0, 0, 0);
    chk("lit.fwft.empty", 32'(f_empty), 0);
    chk("lit.fwft.rd_valid", 32'(f_rd_valid), 1);
    chk("lit.fwft.rd_data", 32'(f_rd_data), 32'hA5);
    drive(0, 8'h00, 1, 0, 0);
    chk("lit.fwft_pop.empty", 32'(f_empty), 1);
    chk("lit.fwft_pop.rd_valid", 32'(f_rd_valid), 0);

    for (int i = 0; i < 5; i++) drive(1, 8'(8'h50 + 8'(i)), 0, 0, 0);
    chk("lit.pre_flush.count", 32'(s_count), 5);
    drive(1, 8'hEE, 0, 1, 0);
    chk("lit.flush_mid.count", 32'(s_count), 0);
    chk("lit.flush_mid.empty", 32'(s_empty), 1);
    drive(1, 8'h3C, 0, 0, 0);
    chk("lit.post_flush.fwft_head", 32'(f_rd_data), 32'h3C);
    drive(0, 8'h00, 1, 0, 0);
    chk("lit.post_flush.rd_data", 32'(s_rd_data), 32'h3C);

    for (int i = 0; i < 6; i++) drive(1, 8'(8'h60 + 8'(i)), 0, 0, 0);
    chk("lit.pre_rst.count", 32'(s_count), 6);
    drive(0, 8'h00, 0, 0, 1);
    chk("lit.rst.count", 32'(s_count), 0);
    chk("lit.rst.empty", 32'(f_empty), 1);
    chk("lit.rst.rd_data", 32'(s_rd_data), 0);
    chk("lit.rst.fwft_rd_data", 32'(f_rd_data), 0);
    chk("lit.rst.fwft_rd_valid", 32'(f_rd_valid), 0);

    for (int blk = 0; blk < 15; blk++) begin
      int wp;
      int rp;
      wp = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int c = 0; c < 200; c++) begin
        drive(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp),
              ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0));
      end
    end
    drive(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
